// File: rtl/dcmac_tx_segmenter.sv
// dcmac_tx_segmenter
//   Converts a wide AXI-Stream packet interface into the per-segment TX
//   interface of a DCMAC port. Every packet starts on segment 0, the EOP
//   lands on the highest occupied segment of the last beat, and protocol
//   errors are flagged on the EOP segment's tuser[0].
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   in_tdata/tkeep/tlast       input beat, segment n in slice n
//   in_tvalid/in_tready        input handshake (ready registered)
//   out<n>_tdata/tkeep         segment n payload and byte enables
//   out<n>_tuser               {SOP, error}
//   out<n>_tlast/tvalid        segment n EOP and valid
//   out_tready                 shared ready from the MAC
//   pkt_count                  accepted packets, wraps
//   err_count                  errored packets, saturates
module dcmac_tx_segmenter #(
  parameter int SEG_COUNT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEG_COUNT*128-1:0] in_tdata,
  input  logic [SEG_COUNT*16-1:0]  in_tkeep,
  input  logic                     in_tlast,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  output logic [127:0]             out0_tdata,
  output logic [15:0]              out0_tkeep,
  output logic [1:0]               out0_tuser,
  output logic                     out0_tlast,
  output logic                     out0_tvalid,
  output logic [127:0]             out1_tdata,
  output logic [15:0]              out1_tkeep,
  output logic [1:0]               out1_tuser,
  output logic                     out1_tlast,
  output logic                     out1_tvalid,
  output logic [127:0]             out2_tdata,
  output logic [15:0]              out2_tkeep,
  output logic [1:0]               out2_tuser,
  output logic                     out2_tlast,
  output logic                     out2_tvalid,
  output logic [127:0]             out3_tdata,
  output logic [15:0]              out3_tkeep,
  output logic [1:0]               out3_tuser,
  output logic                     out3_tlast,
  output logic                     out3_tvalid,
  input  logic                     out_tready,
  output logic [31:0]              pkt_count,
  output logic [15:0]              err_count
);

  localparam int KW = SEG_COUNT * 16;

  // One fully formatted output beat; always sized for four segments so that
  // unused segments stay at their reset value of zero.
  typedef struct packed {
    logic [3:0][127:0] data;
    logic [3:0][15:0]  keep;
    logic [3:0][1:0]   user;
    logic [3:0]        last;
    logic [3:0]        valid;
  } beat_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t      state_q, state_d;
  logic        sop;
  beat_t       out_q, out_d;
  beat_t       skid_q, skid_d;
  beat_t       fmt_beat;
  logic        skid_valid_q, skid_valid_d;
  logic        in_tready_q, in_tready_d;
  logic        err_flag_q, err_flag_d;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [15:0] err_count_q, err_count_d;

  logic        accept;
  logic        out_free;
  logic        keep_zero;
  logic        keep_full;
  logic        keep_contig;
  logic        beat_err;
  logic        eop_err;
  logic [1:0]  last_seg;

  assign accept   = in_tvalid && in_tready_q;
  // The output register may take a new beat when empty or being consumed.
  assign out_free = (out_q.valid == 4'b0000) || out_tready;

  // Byte enables must form a run of ones starting at byte 0; x & (x+1) is
  // zero exactly for such prefixes (including all-zero).
  assign keep_zero   = (in_tkeep == '0);
  assign keep_full   = &in_tkeep;
  assign keep_contig = ((in_tkeep & (in_tkeep + KW'(1))) == '0);
  assign beat_err    = (!in_tlast && !keep_full) || !keep_contig ||
                       (in_tlast && keep_zero);
  assign eop_err     = err_flag_q || beat_err;

  // Highest occupied segment; stays 0 for an all-zero keep so the empty
  // EOP still lands on segment 0.
  always_comb begin
    last_seg = 2'd0;
    for (int n = 0; n < SEG_COUNT; n++) begin
      if (|in_tkeep[n*16 +: 16]) begin
        last_seg = 2'(n);
      end
    end
  end

  // Build the output beat from the current input beat.
  always_comb begin
    fmt_beat = '0;
    for (int n = 0; n < SEG_COUNT; n++) begin
      if (!in_tlast || (!keep_zero && (2'(n) <= last_seg))) begin
        fmt_beat.data[n]  = in_tdata[n*128 +: 128];
        fmt_beat.keep[n]  = in_tkeep[n*16 +: 16];
        fmt_beat.valid[n] = 1'b1;
      end
    end
    if (in_tlast) begin
      fmt_beat.last[last_seg]    = 1'b1;
      fmt_beat.user[last_seg][0] = eop_err;
      fmt_beat.valid[0]          = 1'b1;
    end
    fmt_beat.user[0][1] = sop;
  end

  // Output register plus one-entry skid. Because in_tready is the registered
  // "skid empty", a beat can never arrive while the skid is full, so draining
  // and accepting never collide and order is preserved.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d = fmt_beat;
      end else begin
        out_d = '0;
      end
    end else if (accept) begin
      skid_d       = fmt_beat;
      skid_valid_d = 1'b1;
    end
    in_tready_d = !skid_valid_d;
  end

  // Packet state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Packet next-state: a tlast beat always closes the packet.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_tlast ? IDLE : IN_PKT;
    end
  end

  // Packet state outputs.
  always_comb begin
    sop = (state_q == IDLE);
  end

  // Sticky per-packet error flag and the statistics counters.
  always_comb begin
    err_flag_d  = err_flag_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    if (accept) begin
      if (in_tlast) begin
        err_flag_d  = 1'b0;
        pkt_count_d = pkt_count_q + 32'd1;
        if (eop_err && (err_count_q != 16'hFFFF)) begin
          err_count_d = err_count_q + 16'd1;
        end
      end else begin
        err_flag_d = eop_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_tready_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_tready_q  <= in_tready_d;
      err_flag_q   <= err_flag_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_tready = in_tready_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

  // Segments at or above SEG_COUNT are never written, so they read as zero.
  assign out0_tdata  = out_q.data[0];
  assign out0_tkeep  = out_q.keep[0];
  assign out0_tuser  = out_q.user[0];
  assign out0_tlast  = out_q.last[0];
  assign out0_tvalid = out_q.valid[0];
  assign out1_tdata  = out_q.data[1];
  assign out1_tkeep  = out_q.keep[1];
  assign out1_tuser  = out_q.user[1];
  assign out1_tlast  = out_q.last[1];
  assign out1_tvalid = out_q.valid[1];
  assign out2_tdata  = out_q.data[2];
  assign out2_tkeep  = out_q.keep[2];
  assign out2_tuser  = out_q.user[2];
  assign out2_tlast  = out_q.last[2];
  assign out2_tvalid = out_q.valid[2];
  assign out3_tdata  = out_q.data[3];
  assign out3_tkeep  = out_q.keep[3];
  assign out3_tuser  = out_q.user[3];
  assign out3_tlast  = out_q.last[3];
  assign out3_tvalid = out_q.valid[3];

endmodule

// File: tb/tb_dcmac_tx_segmenter.sv
// tb_dcmac_tx_segmenter
//   Drives a two-segment and a four-segment instance with directed beats.
//   Expected output beats are queued when a beat is accepted and popped by a
//   monitor whenever a DUT hands a beat to the MAC.
module tb_dcmac_tx_segmenter;

  typedef struct packed {
    logic [3:0][127:0] data;
    logic [3:0][15:0]  keep;
    logic [3:0][1:0]   user;
    logic [3:0]        last;
    logic [3:0]        valid;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  exp_t queueA[$];
  exp_t queueB[$];

  // Two-segment instance signals
  logic [255:0]      aInData = '0;
  logic [31:0]       aInKeep = '0;
  logic              aInLast = 1'b0;
  logic              aInValid = 1'b0;
  logic              aInReady;
  logic              aOutReady = 1'b1;
  logic [3:0][127:0] aData;
  logic [3:0][15:0]  aKeep;
  logic [3:0][1:0]   aUser;
  logic [3:0]        aLast;
  logic [3:0]        aValid;
  logic [31:0]       aPktCount;
  logic [15:0]       aErrCount;

  // Four-segment instance signals
  logic [511:0]      bInData = '0;
  logic [63:0]       bInKeep = '0;
  logic              bInLast = 1'b0;
  logic              bInValid = 1'b0;
  logic              bInReady;
  logic              bOutReady = 1'b1;
  logic [3:0][127:0] bData;
  logic [3:0][15:0]  bKeep;
  logic [3:0][1:0]   bUser;
  logic [3:0]        bLast;
  logic [3:0]        bValid;
  logic [31:0]       bPktCount;
  logic [15:0]       bErrCount;

  dcmac_tx_segmenter #(.SEG_COUNT(2)) dutA (
    .clk(clk), .reset(reset),
    .in_tdata(aInData), .in_tkeep(aInKeep), .in_tlast(aInLast),
    .in_tvalid(aInValid), .in_tready(aInReady),
    .out0_tdata(aData[0]), .out0_tkeep(aKeep[0]), .out0_tuser(aUser[0]),
    .out0_tlast(aLast[0]), .out0_tvalid(aValid[0]),
    .out1_tdata(aData[1]), .out1_tkeep(aKeep[1]), .out1_tuser(aUser[1]),
    .out1_tlast(aLast[1]), .out1_tvalid(aValid[1]),
    .out2_tdata(aData[2]), .out2_tkeep(aKeep[2]), .out2_tuser(aUser[2]),
    .out2_tlast(aLast[2]), .out2_tvalid(aValid[2]),
    .out3_tdata(aData[3]), .out3_tkeep(aKeep[3]), .out3_tuser(aUser[3]),
    .out3_tlast(aLast[3]), .out3_tvalid(aValid[3]),
    .out_tready(aOutReady), .pkt_count(aPktCount), .err_count(aErrCount)
  );

  dcmac_tx_segmenter #(.SEG_COUNT(4)) dutB (
    .clk(clk), .reset(reset),
    .in_tdata(bInData), .in_tkeep(bInKeep), .in_tlast(bInLast),
    .in_tvalid(bInValid), .in_tready(bInReady),
    .out0_tdata(bData[0]), .out0_tkeep(bKeep[0]), .out0_tuser(bUser[0]),
    .out0_tlast(bLast[0]), .out0_tvalid(bValid[0]),
    .out1_tdata(bData[1]), .out1_tkeep(bKeep[1]), .out1_tuser(bUser[1]),
    .out1_tlast(bLast[1]), .out1_tvalid(bValid[1]),
    .out2_tdata(bData[2]), .out2_tkeep(bKeep[2]), .out2_tuser(bUser[2]),
    .out2_tlast(bLast[2]), .out2_tvalid(bValid[2]),
    .out3_tdata(bData[3]), .out3_tkeep(bKeep[3]), .out3_tuser(bUser[3]),
    .out3_tlast(bLast[3]), .out3_tvalid(bValid[3]),
    .out_tready(bOutReady), .pkt_count(bPktCount), .err_count(bErrCount)
  );

  // Recognisable payload: segment n of beat id is {id, n} repeated.
  function automatic logic [511:0] mkData(input logic [7:0] id);
    logic [511:0] d;
    for (int n = 0; n < 4; n++) begin
      d[n*128 +: 128] = {8{id, 8'(n)}};
    end
    return d;
  endfunction

  function automatic exp_t setSeg(input exp_t e, input int n, input logic [511:0] d,
                                  input logic [15:0] k, input logic [1:0] u, input logic l);
    exp_t r;
    r = e;
    r.data[n]  = d[n*128 +: 128];
    r.keep[n]  = k;
    r.user[n]  = u;
    r.last[n]  = l;
    r.valid[n] = 1'b1;
    return r;
  endfunction

  // Non-last beat with all bytes present on nSeg segments.
  function automatic exp_t fullBeat(input logic [511:0] d, input int nSeg, input logic sop);
    exp_t r;
    r = '0;
    for (int n = 0; n < nSeg; n++) begin
      r = setSeg(r, n, d, 16'hFFFF, {(n == 0) && sop, 1'b0}, 1'b0);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Data is compared on enabled bytes of valid segments; invalid segments
  // must be all zero.
  task automatic compareBeat(input string name, input exp_t act, input exp_t e);
    logic [3:0][127:0] mask;
    mask = '0;
    for (int n = 0; n < 4; n++) begin
      for (int b = 0; b < 16; b++) begin
        mask[n][b*8 +: 8] = (!e.valid[n] || e.keep[n][b]) ? 8'hFF : 8'h00;
      end
    end
    checks++;
    if ({act.keep, act.user, act.last, act.valid} !== {e.keep, e.user, e.last, e.valid}) begin
      failures++;
      $display("[TB] FAIL %s_meta got keep=%h user=%h last=%b valid=%b required keep=%h user=%h last=%b valid=%b",
               name, act.keep, act.user, act.last, act.valid, e.keep, e.user, e.last, e.valid);
    end
    checks++;
    if ((act.data & mask) !== (e.data & mask)) begin
      failures++;
      $display("[TB] FAIL %s_data got=%h required=%h", name, act.data & mask, e.data & mask);
    end
  endtask

  // Monitors sample just before the rising edge, when both the DUT outputs
  // and out_tready are settled for the handshake that edge completes.
  always @(negedge clk) begin
    #4;
    if (aOutReady && (aValid != 4'b0000)) begin
      if (queueA.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL segA_unexpected got valid=%b required no beat", aValid);
      end else begin
        compareBeat("segA", exp_t'({aData, aKeep, aUser, aLast, aValid}), queueA.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #4;
    if (bOutReady && (bValid != 4'b0000)) begin
      if (queueB.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL segB_unexpected got valid=%b required no beat", bValid);
      end else begin
        compareBeat("segB", exp_t'({bData, bKeep, bUser, bLast, bValid}), queueB.pop_front());
      end
    end
  end

  // Presents one beat from a falling edge and returns on the falling edge
  // after it was accepted.
  task automatic applyStimulus(input int sel, input logic [511:0] d, input logic [63:0] k,
                               input logic l, input exp_t e);
    int waited;
    waited = 0;
    if (sel == 0) begin
      aInData = d[255:0]; aInKeep = k[31:0]; aInLast = l; aInValid = 1'b1;
    end else begin
      bInData = d; bInKeep = k; bInLast = l; bInValid = 1'b1;
    end
    while (((sel == 0) ? aInReady : bInReady) == 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (((sel == 0) ? aInReady : bInReady) == 1'b0) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout sel=%0d got ready=0 required ready=1", sel);
    end else begin
      if (sel == 0) queueA.push_back(e);
      else queueB.push_back(e);
      @(posedge clk);
      @(negedge clk);
    end
    aInValid = 1'b0;
    bInValid = 1'b0;
  endtask

  task automatic waitDrain(input int sel);
    int waited;
    waited = 0;
    while (((sel == 0) ? queueA.size() : queueB.size()) != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    checkOutput((sel == 0) ? "drainA" : "drainB",
                64'((sel == 0) ? queueA.size() : queueB.size()), 64'd0);
  endtask

  logic [511:0] d0, d1, d2, d3;
  exp_t e;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_validA", 64'(aValid), 64'h0);
    checkOutput("rst_dataA0", 64'(aData[0][63:0]), 64'h0);
    checkOutput("rst_readyA", 64'(aInReady), 64'h0);
    checkOutput("rst_pktA", 64'(aPktCount), 64'h0);
    checkOutput("rst_errA", 64'(aErrCount), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_readyA", 64'(aInReady), 64'h1);
    checkOutput("post_rst_readyB", 64'(bInReady), 64'h1);

    // Three-beat packet, last beat fills one and a half segments
    d0 = mkData(8'h11); d1 = mkData(8'h12); d2 = mkData(8'h13);
    applyStimulus(0, d0, 64'hFFFF_FFFF, 1'b0, fullBeat(d0, 2, 1'b1));
    applyStimulus(0, d1, 64'hFFFF_FFFF, 1'b0, fullBeat(d1, 2, 1'b0));
    e = '0;
    e = setSeg(e, 0, d2, 16'hFFFF, 2'b00, 1'b0);
    e = setSeg(e, 1, d2, 16'h00FF, 2'b00, 1'b1);
    applyStimulus(0, d2, 64'h00FF_FFFF, 1'b1, e);
    waitDrain(0);
    checkOutput("pkt3beat_pkt", 64'(aPktCount), 64'd1);
    checkOutput("pkt3beat_err", 64'(aErrCount), 64'd0);

    // Four-beat stream with a five-cycle MAC stall
    d0 = mkData(8'h21); d1 = mkData(8'h22); d2 = mkData(8'h23); d3 = mkData(8'h24);
    fork
      begin
        applyStimulus(0, d0, 64'hFFFF_FFFF, 1'b0, fullBeat(d0, 2, 1'b1));
        applyStimulus(0, d1, 64'hFFFF_FFFF, 1'b0, fullBeat(d1, 2, 1'b0));
        applyStimulus(0, d2, 64'hFFFF_FFFF, 1'b0, fullBeat(d2, 2, 1'b0));
        e = '0;
        e = setSeg(e, 0, d3, 16'hFFFF, 2'b00, 1'b0);
        e = setSeg(e, 1, d3, 16'hFFFF, 2'b00, 1'b1);
        applyStimulus(0, d3, 64'hFFFF_FFFF, 1'b1, e);
      end
      begin
        @(posedge clk);
        #2 aOutReady = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if ({aData[1], aData[0]} !== d0[255:0]) begin
            failures++;
            $display("[TB] FAIL stall_data got=%h required=%h", {aData[1], aData[0]}, d0[255:0]);
          end
          checkOutput("stall_valid", 64'(aValid), 64'h3);
          checkOutput("stall_user0", 64'(aUser[0]), 64'h2);
        end
        checkOutput("stall_in_ready", 64'(aInReady), 64'h0);
        @(posedge clk);
        #2 aOutReady = 1'b1;
      end
    join
    waitDrain(0);
    checkOutput("stall_pkt", 64'(aPktCount), 64'd2);

    // Errored packet (missing byte on a non-last beat), then a clean one
    d0 = mkData(8'h31); d1 = mkData(8'h32); d2 = mkData(8'h33);
    e = '0;
    e = setSeg(e, 0, d0, 16'hFFFE, 2'b10, 1'b0);
    e = setSeg(e, 1, d0, 16'hFFFF, 2'b00, 1'b0);
    applyStimulus(0, d0, 64'hFFFF_FFFE, 1'b0, e);
    e = '0;
    e = setSeg(e, 0, d1, 16'hFFFF, 2'b00, 1'b0);
    e = setSeg(e, 1, d1, 16'hFFFF, 2'b01, 1'b1);
    applyStimulus(0, d1, 64'hFFFF_FFFF, 1'b1, e);
    e = '0;
    e = setSeg(e, 0, d2, 16'h00FF, 2'b10, 1'b1);
    applyStimulus(0, d2, 64'h0000_00FF, 1'b1, e);
    waitDrain(0);
    checkOutput("errpkt_err", 64'(aErrCount), 64'd1);
    checkOutput("errpkt_pkt", 64'(aPktCount), 64'd4);

    // Empty EOP beat
    d0 = mkData(8'h41);
    e = '0;
    e = setSeg(e, 0, d0, 16'h0000, 2'b11, 1'b1);
    applyStimulus(0, d0, 64'h0, 1'b1, e);
    // Non-contiguous keep on a single-beat packet
    d1 = mkData(8'h42);
    e = '0;
    e = setSeg(e, 0, d1, 16'hFF00, 2'b11, 1'b1);
    applyStimulus(0, d1, 64'h0000_FF00, 1'b1, e);
    waitDrain(0);
    checkOutput("empty_noncontig_err", 64'(aErrCount), 64'd3);
    checkOutput("empty_noncontig_pkt", 64'(aPktCount), 64'd6);

    // Four-segment instance: half-filled single beat, full single beat,
    // then a two-beat packet ending on segment 0
    d0 = mkData(8'h51); d1 = mkData(8'h52); d2 = mkData(8'h53); d3 = mkData(8'h54);
    e = '0;
    e = setSeg(e, 0, d0, 16'hFFFF, 2'b10, 1'b0);
    e = setSeg(e, 1, d0, 16'hFFFF, 2'b00, 1'b1);
    applyStimulus(1, d0, 64'h0000_0000_FFFF_FFFF, 1'b1, e);
    e = fullBeat(d1, 4, 1'b1);
    e.last[3] = 1'b1;
    applyStimulus(1, d1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, e);
    applyStimulus(1, d2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, fullBeat(d2, 4, 1'b1));
    e = '0;
    e = setSeg(e, 0, d3, 16'hFFFF, 2'b00, 1'b1);
    applyStimulus(1, d3, 64'h0000_0000_0000_FFFF, 1'b1, e);
    waitDrain(1);
    checkOutput("seg4_pkt", 64'(bPktCount), 64'd3);
    checkOutput("seg4_err", 64'(bErrCount), 64'd0);

    // Reset in the middle of a packet
    d0 = mkData(8'h61); d1 = mkData(8'h62); d2 = mkData(8'h63);
    applyStimulus(0, d0, 64'hFFFF_FFFF, 1'b0, fullBeat(d0, 2, 1'b1));
    applyStimulus(0, d1, 64'hFFFF_FFFF, 1'b0, fullBeat(d1, 2, 1'b0));
    waitDrain(0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(aValid), 64'h0);
    checkOutput("midrst_ready", 64'(aInReady), 64'h0);
    checkOutput("midrst_pkt", 64'(aPktCount), 64'h0);
    checkOutput("midrst_err", 64'(aErrCount), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready_after", 64'(aInReady), 64'h1);
    e = '0;
    e = setSeg(e, 0, d2, 16'hFFFF, 2'b10, 1'b0);
    e = setSeg(e, 1, d2, 16'hFFFF, 2'b00, 1'b1);
    applyStimulus(0, d2, 64'hFFFF_FFFF, 1'b1, e);
    waitDrain(0);
    checkOutput("midrst_newpkt", 64'(aPktCount), 64'd1);
    checkOutput("midrst_newerr", 64'(aErrCount), 64'd0);

    // Error counter saturation using empty EOP beats
    d0 = mkData(8'h71);
    e = '0;
    e = setSeg(e, 0, d0, 16'h0000, 2'b11, 1'b1);
    for (int i = 0; i < 65534; i++) begin
      applyStimulus(0, d0, 64'h0, 1'b1, e);
    end
    waitDrain(0);
    checkOutput("sat_fffe", 64'(aErrCount), 64'hFFFE);
    applyStimulus(0, d0, 64'h0, 1'b1, e);
    waitDrain(0);
    checkOutput("sat_ffff", 64'(aErrCount), 64'hFFFF);
    applyStimulus(0, d0, 64'h0, 1'b1, e);
    applyStimulus(0, d0, 64'h0, 1'b1, e);
    waitDrain(0);
    checkOutput("sat_hold", 64'(aErrCount), 64'hFFFF);
    checkOutput("sat_pkt", 64'(aPktCount), 64'd65538);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcmac_tx_segmenter.md
DCMAC_TX_SEGMENTER -- requirements
Module: dcmac_tx_segmenter

Interface
REQ-001 SHALL have parameter SEG_COUNT, default 2, number of 128-bit DCMAC TX segments per port (legal values 2 or 4).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_tdata  input  SEG_COUNT*128  packet data; segment n = bits [128n+127:128n].
REQ-006 in_tkeep  input  SEG_COUNT*16  byte enables; segment n = bits [16n+15:16n].
REQ-007 in_tlast  input  1  last beat of packet.
REQ-008 in_tvalid / in_tready  input / output  1 each  AXI-Stream handshake.
REQ-009 out<n>_tdata, n=0..3  output  128  segment n data.
REQ-010 out<n>_tkeep  output  16  segment n byte enables.
REQ-011 out<n>_tuser  output  2  bit1 = SOP, bit0 = error.
REQ-012 out<n>_tlast  output  1  EOP on segment n.
REQ-013 out<n>_tvalid  output  1  segment n valid.
REQ-014 out_tready  input  1  shared DCMAC TX ready.
REQ-015 pkt_count  output  32  accepted packets, wraps.
REQ-016 err_count  output  16  errored packets, saturates at 0xFFFF.

Function
REQ-017 A segment SHALL be occupied when any of its tkeep bits is 1.
REQ-018 Data path SHALL be an output register plus a one-entry skid buffer; in_tready SHALL be registered and equal "skid empty".
REQ-019 Latency in->out SHALL be 1 cycle when out_tready=1 and the skid is empty.
REQ-020 While any out<n>_tvalid=1 and out_tready=0, all out* signals SHALL hold stable.
REQ-021 A beat accepted while in_tready=1 and the output is stalled SHALL go to the skid; in_tready SHALL go 0 the next cycle and return to 1 one cycle after the skid drains.
REQ-022 Packet FSM states: IDLE, IN_PKT; IDLE->IN_PKT on an accepted beat with tlast=0; IN_PKT->IDLE on an accepted beat with tlast=1; single-beat packets stay in IDLE.
REQ-023 The first beat of every packet SHALL always start on segment 0, with out0_tuser[1]=1; out0_tuser[1]=0 on every other beat, and tuser[1]=0 on all other segments.
REQ-024 Beat without tlast: every segment SHALL be output with tvalid=1 and tlast=0.
REQ-025 Beat with tlast: the highest occupied segment k SHALL have tlast=1, and segments 0..k SHALL have tvalid=1.
REQ-026 On a tlast beat, segments above k SHALL have tvalid=0, tdata=0, tkeep=0, tuser=0.
REQ-027 Protocol errors: a non-last beat without all tkeep=1; non-contiguous tkeep across the beat; a tlast beat with tkeep all zero.
REQ-028 Any protocol error SHALL set a per-packet sticky error flag.
REQ-029 The error flag SHALL drive tuser[0]=1 on the EOP segment, and err_count SHALL increment once per errored packet.
REQ-030 A tlast beat with all tkeep zero SHALL emit segment 0 with tkeep=0, tlast=1, tuser[0]=1, and tvalid=1 on segment 0 only.
REQ-031 pkt_count SHALL increment on each accepted tlast beat, wrapping at 2^32.
REQ-032 When SEG_COUNT=2, out2_* and out3_* SHALL be constant 0.
REQ-033 Simultaneous skid drain and new input SHALL neither lose nor reorder beats.

Reset
REQ-034 While reset=1: all out* = 0, in_tready=0, skid empty, FSM=IDLE, error flag clear, pkt_count=0, err_count=0.
REQ-035 in_tready SHALL be 1 on the first cycle after reset deasserts.
REQ-036 Reset mid-packet SHALL discard the partial packet, with no EOP emitted; the next accepted beat SHALL be treated as SOP.

Verification
REQ-037 SEG_COUNT=2, 3-beat packet, last tkeep=0x00FF_FFFF (low half full), out_tready=1 -> beat1 out0 tuser=2'b10; beat3 out1 tlast=1 with tkeep 0x00FF, both segments valid; pkt_count=1.
REQ-038 SEG_COUNT=4, single beat with tkeep=0x0000_0000_FFFF_FFFF, tlast=1 -> same-cycle-plus-1 out0 tuser[1]=1, out1 tlast=1; out2/out3 tvalid=0; FSM stays IDLE.
REQ-039 Hold out_tready=0 for 5 cycles during a 4-beat stream -> outputs stable; in_tready=0 after the skid fills; all 4 beats emerge in order with no duplicates.
REQ-040 Non-last beat with tkeep missing one byte -> EOP segment of that packet has tuser[0]=1; err_count=1; next packet has tuser[0]=0.
REQ-041 Assert reset for 1 cycle after beat 2 of a 4-beat packet, then send a new 1-beat packet -> new beat has out0 tuser[1]=1; pkt_count=1.
REQ-042 err_count preloaded via 65536 errored packets, then one more -> err_count remains 0xFFFF.
